vppm_freq_meter: RTL and testbench

- Parametrised successor to the VPPM receiver's preamble frequency detector. Measures the incoming VPPM bit rate on `signalIn` and reports the averaged bit period and the bit frequency.
- Fully synchronous to `clk`: input synchroniser, edge detector, averaging over 2^AVG_LOG2 periods, glitch rejection, loss-of-signal timeout, optional continuous tracking.
- Uses a sequential divider instead of a combinational one.
- Feeds the VPPM slot-timing / demodulator logic downstream.

---
 rtl/vppm_freq_meter.sv | 175 +++++++++++++++++
 tb/tb_vppm_freq_meter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vppm_freq_meter.sv
// VPPM bit-rate meter: averages 2^AVG_LOG2 rising-edge intervals of signalIn and
// reports the mean period (clk cycles) and bit frequency (Hz) via a serial divider.
//   state   | meaning
//   IDLE    | no acquisition; any edge starts one
//   MEASURE | accumulating accepted intervals into sum
//   DIVIDE  | 32-cycle restoring divide of the scaled clock rate by sum
//   LOCKED  | result held; with TRACK, next accepted edge starts a new measurement
module vppm_freq_meter #(
    parameter int unsigned CLK_FREQ   = 200000000,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned TRACK      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signalIn,
    input  logic             rearm,
    output logic [31:0]      frequency,
    output logic [CNT_W-1:0] period,
    output logic             freq_valid,
    output logic             locked,
    output logic             lock_lost
);

    localparam logic [63:0]      NUMERATOR = 64'(CLK_FREQ) << AVG_LOG2;
    localparam logic [31:0]      NUM_HI    = NUMERATOR[63:32];
    localparam logic [31:0]      NUM_LO    = NUMERATOR[31:0];
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [4:0]       LAST_N    = 5'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, LOCKED} meterState_t;

    meterState_t      state, stateNext;
    logic             syncA, syncB, syncC, edgeEvt;
    logic [CNT_W-1:0] ivl, sum, sumNext;
    logic [4:0]       nCnt;
    logic [CNT_W-1:0] divRem, remStep, remInit;
    logic [31:0]      divNum, divQuo;
    logic [4:0]       divCnt;
    logic             divOvf, ovfNext;
    logic [CNT_W:0]   shifted;
    logic             stepGe;
    logic             edgeAcc, timeoutHit;
    logic             startMeas, accum, startDiv, finishDiv, toutEvt;

    assign edgeAcc    = edgeEvt && !rearm && ((state == IDLE) || (ivl >= MIN_C));
    assign timeoutHit = (state != IDLE) && (ivl == TIMEOUT_C) && !edgeAcc;
    assign sumNext    = sum + ivl;
    // Quotient needs more than 32 bits whenever the upper numerator word alone reaches the divisor.
    assign ovfNext    = {32'd0, NUM_HI} >= 64'(sumNext);
    assign remInit    = CNT_W'(NUM_HI);

    always_comb begin
        shifted = {divRem, divNum[31]};
        stepGe  = shifted >= {1'b0, sum};
        remStep = stepGe ? CNT_W'(shifted - {1'b0, sum}) : shifted[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        startMeas = 1'b0;
        accum     = 1'b0;
        startDiv  = 1'b0;
        finishDiv = 1'b0;
        toutEvt   = 1'b0;
        if (rearm) begin
            stateNext = IDLE;
        end else if (timeoutHit) begin
            stateNext = IDLE;
            toutEvt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (edgeAcc) begin
                        stateNext = MEASURE;
                        startMeas = 1'b1;
                    end
                end
                MEASURE: begin
                    if (edgeAcc) begin
                        accum = 1'b1;
                        if (nCnt == LAST_N) begin
                            stateNext = DIVIDE;
                            startDiv  = 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (divCnt == 5'd31) begin
                        stateNext = LOCKED;
                        finishDiv = 1'b1;
                    end
                end
                LOCKED: begin
                    if ((TRACK != 0) && edgeAcc) begin
                        stateNext = MEASURE;
                        startMeas = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncA      <= 1'b0;
            syncB      <= 1'b0;
            syncC      <= 1'b0;
            edgeEvt    <= 1'b0;
            ivl        <= '0;
            sum        <= '0;
            nCnt       <= '0;
            divRem     <= '0;
            divNum     <= '0;
            divQuo     <= '0;
            divCnt     <= '0;
            divOvf     <= 1'b0;
            frequency  <= '0;
            period     <= '0;
            freq_valid <= 1'b0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            syncA      <= signalIn;
            syncB      <= syncA;
            syncC      <= syncB;
            edgeEvt    <= syncB & ~syncC;
            freq_valid <= finishDiv;
            lock_lost  <= toutEvt;

            if (rearm)                 ivl <= '0;
            else if (edgeAcc)          ivl <= CNT_W'(1);
            else if (ivl < TIMEOUT_C)  ivl <= ivl + CNT_W'(1);

            if (rearm || startMeas) begin
                sum  <= '0;
                nCnt <= '0;
            end else if (accum) begin
                sum  <= sumNext;
                nCnt <= nCnt + 5'd1;
            end

            if (startDiv) begin
                divRem <= remInit;
                divNum <= NUM_LO;
                divQuo <= '0;
                divCnt <= '0;
                divOvf <= ovfNext;
            end else if (state == DIVIDE) begin
                divRem <= remStep;
                divNum <= {divNum[30:0], 1'b0};
                divQuo <= {divQuo[30:0], stepGe};
                divCnt <= divCnt + 5'd1;
            end

            if (finishDiv) begin
                frequency <= divOvf ? 32'hFFFF_FFFF : {divQuo[30:0], stepGe};
                period    <= sum >> AVG_LOG2;
            end

            if (rearm || toutEvt) locked <= 1'b0;
            else if (finishDiv)   locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vppm_freq_meter.sv
// Scoreboard bench for vppm_freq_meter: a hold-mode and a tracking instance share stimulus;
// expected updates come from interval lists and plain arithmetic.
module tb_vppm_freq_meter;

    localparam int unsigned CLK_FREQ   = 200000000;
    localparam int unsigned AVG_LOG2   = 2;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned MIN_PERIOD = 16;
    localparam int unsigned TIMEOUT    = 4100;
    localparam int          AVG_N      = 1 << AVG_LOG2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             signalIn = 1'b0;
    logic             rearm = 1'b0;
    logic [31:0]      frequency0, frequency1;
    logic [CNT_W-1:0] period0, period1;
    logic             fv0, fv1, lk0, lk1, ll0, ll1;

    always #5 clk = ~clk;

    vppm_freq_meter #(.CLK_FREQ(CLK_FREQ), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W),
                      .MIN_PERIOD(MIN_PERIOD), .TIMEOUT(TIMEOUT), .TRACK(0)) dutHold (
        .clk(clk), .reset(reset), .signalIn(signalIn), .rearm(rearm),
        .frequency(frequency0), .period(period0), .freq_valid(fv0),
        .locked(lk0), .lock_lost(ll0));

    vppm_freq_meter #(.CLK_FREQ(CLK_FREQ), .AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W),
                      .MIN_PERIOD(MIN_PERIOD), .TIMEOUT(TIMEOUT), .TRACK(1)) dutTrack (
        .clk(clk), .reset(reset), .signalIn(signalIn), .rearm(rearm),
        .frequency(frequency1), .period(period1), .freq_valid(fv1),
        .locked(lk1), .lock_lost(ll1));

    typedef struct packed {
        logic [31:0] freq;
        logic [31:0] per;
    } expT;

    expT         expQ0[$], expQ1[$];
    int          lostQ0[$], lostQ1[$];
    logic [31:0] holdFreq[2];
    logic [31:0] holdPer[2];
    int          total = 0;
    int          passed = 0;
    int          segIvl[$];
    int          segGlitch[$];

    task automatic cmp(input string name, input int w, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %0d expected %0d", name, w, act, exp);
    endtask

    // Mean of one group of intervals and the resulting frequency, saturated to 32 bits.
    function automatic expT refResult(input int first);
        expT    r;
        longint s = 0;
        longint q;
        for (int k = 0; k < AVG_N; k++) s += segIvl[first + k];
        q = (longint'(CLK_FREQ) << AVG_LOG2) / s;
        if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
        r.freq = 32'(q);
        r.per  = 32'(s >> AVG_LOG2);
        return r;
    endfunction

    // Hold mode: only the first group counts. Tracking: each group is followed by one
    // interval whose closing edge starts the next group.
    task automatic pushModel();
        int n = segIvl.size();
        if (n >= AVG_N) expQ0.push_back(refResult(0));
        for (int idx = 0; idx + AVG_N <= n; idx += AVG_N + 1) expQ1.push_back(refResult(idx));
    endtask

    task automatic checkDut(input int w, input logic fv, input logic [31:0] f,
                            input logic [31:0] p, input logic lk, input logic ll);
        expT e;
        int  qs;
        if (fv) begin
            qs = (w == 0) ? expQ0.size() : expQ1.size();
            if (qs == 0) begin
                total++;
                $display("FAIL unexpected_freq_valid dut%0d: got freq %0d expected no update", w, f);
            end else begin
                if (w == 0) e = expQ0.pop_front();
                else        e = expQ1.pop_front();
                cmp("frequency", w, f, e.freq);
                cmp("period", w, p, e.per);
                cmp("locked_on_update", w, lk, 1);
                holdFreq[w] = e.freq;
                holdPer[w]  = e.per;
            end
        end
        if (ll) begin
            qs = (w == 0) ? lostQ0.size() : lostQ1.size();
            if (qs == 0) begin
                total++;
                $display("FAIL unexpected_lock_lost dut%0d: got pulse expected none", w);
            end else begin
                if (w == 0) void'(lostQ0.pop_front());
                else        void'(lostQ1.pop_front());
                cmp("locked_after_loss", w, lk, 0);
                cmp("freq_hold_after_loss", w, f, holdFreq[w]);
                cmp("period_hold_after_loss", w, p, holdPer[w]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkDut(0, fv0, frequency0, period0, lk0, ll0);
            checkDut(1, fv1, frequency1, period1, lk1, ll1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveSegment();
        for (int i = 0; i < segIvl.size(); i++) begin
            int hi;
            hi = segIvl[i] / 2;
            signalIn = 1'b1;
            if (segGlitch[i] > 0) begin
                step(2);
                signalIn = 1'b0;
                step(segGlitch[i] - 2);
                signalIn = 1'b1;
                step(hi - segGlitch[i]);
            end else begin
                step(hi);
            end
            signalIn = 1'b0;
            step(segIvl[i] - hi);
        end
    endtask

    task automatic endByTimeout();
        signalIn = 1'b1;
        step(20);
        signalIn = 1'b0;
        lostQ0.push_back(1);
        lostQ1.push_back(1);
        step(TIMEOUT + 60);
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, "_frequency"}, 0, frequency0, 0);
        cmp({tag, "_frequency"}, 1, frequency1, 0);
        cmp({tag, "_period"}, 0, period0, 0);
        cmp({tag, "_period"}, 1, period1, 0);
        cmp({tag, "_locked"}, 0, lk0, 0);
        cmp({tag, "_locked"}, 1, lk1, 0);
        cmp({tag, "_flags"}, 0, {fv0, ll0}, 0);
        cmp({tag, "_flags"}, 1, {fv1, ll1}, 0);
    endtask

    task automatic setSeg(input int ivls[], input int glitchIdx, input int glitchOff);
        segIvl.delete();
        segGlitch.delete();
        foreach (ivls[i]) begin
            segIvl.push_back(ivls[i]);
            segGlitch.push_back((i == glitchIdx) ? glitchOff : 0);
        end
    endtask

    initial begin
        int d;
        holdFreq[0] = '0; holdFreq[1] = '0;
        holdPer[0]  = '0; holdPer[1]  = '0;

        step(4);
        checkAllZero("reset");
        reset = 1'b1;
        step(10);

        // 100 kHz with jitter, a rejected glitch 15 cycles after a real rise, then a slow-down.
        setSeg('{1999, 2001, 2000, 2000, 2000, 4000, 4000, 4000, 4000}, 1, MIN_PERIOD - 1);
        pushModel();
        driveSegment();
        endByTimeout();

        // Rearm while dividing: the measurement is discarded.
        setSeg('{2000, 2000, 2000, 2000}, -1, 0);
        driveSegment();
        d = $urandom_range(30, 5);
        signalIn = 1'b1;
        step(d);
        rearm = 1'b1;
        step(1);
        rearm = 1'b0;
        signalIn = 1'b0;
        step(3);
        cmp("locked_after_rearm", 0, lk0, 0);
        cmp("locked_after_rearm", 1, lk1, 0);
        cmp("freq_hold_after_rearm", 0, frequency0, holdFreq[0]);
        cmp("freq_hold_after_rearm", 1, frequency1, holdFreq[1]);
        step(500);

        // Fresh acquisition, then an interval landing exactly on TIMEOUT (edge wins).
        setSeg('{2000, 2000, 2000, 2000, TIMEOUT, 100, 100, 100, 100}, -1, 0);
        pushModel();
        driveSegment();
        endByTimeout();

        // Intervals exactly at MIN_PERIOD are accepted.
        setSeg('{MIN_PERIOD, MIN_PERIOD, 100, 100}, -1, 0);
        pushModel();
        driveSegment();
        endByTimeout();

        // Asynchronous reset in the middle of a measurement.
        setSeg('{300, 300}, -1, 0);
        driveSegment();
        signalIn = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        step(3);
        reset = 1'b1;
        signalIn = 1'b0;
        holdFreq[0] = '0; holdFreq[1] = '0;
        holdPer[0]  = '0; holdPer[1]  = '0;
        step(100);

        for (int r = 0; r < 2; r++) begin
            int n;
            segIvl.delete();
            segGlitch.delete();
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) begin
                segIvl.push_back($urandom_range(200, 64));
                segGlitch.push_back(($urandom_range(3, 0) == 0) ? $urandom_range(MIN_PERIOD - 1, 4) : 0);
            end
            pushModel();
            driveSegment();
            endByTimeout();
        end

        cmp("leftover_updates", 0, expQ0.size(), 0);
        cmp("leftover_updates", 1, expQ1.size(), 0);
        cmp("leftover_losses", 0, lostQ0.size(), 0);
        cmp("leftover_losses", 1, lostQ1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
